bus: RTL and testbench

BUS -- requirements
Module: bus

---
 rtl/bus.sv | 103 ++++++++++
 tb/tb_bus.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bus.sv
// bus: single shared bus with round-robin grant and fixed transfer latency
//   clk_in            rising-edge clock
//   rst_l             asynchronous active-low reset
//   request_in_avail  per-source request level, held until accepted
//   addrs_in          per-source transfer address
//   request_dest      per-source destination index (values >= NUM_PROC are dropped)
//   processed_request one-cycle accept pulse to the granted source
//   request_out_avail one-cycle delivery pulse to the destination
//   addrs_out         per-destination address, holds last delivered value
module bus #(
  parameter int NUM_PROC = 4,
  parameter int LATENCY  = 4
) (
  input  logic                                    clk_in,
  input  logic                                    rst_l,
  input  logic [NUM_PROC-1:0]                     request_in_avail,
  input  logic [NUM_PROC-1:0][47:0]               addrs_in,
  input  logic [NUM_PROC-1:0][$clog2(NUM_PROC):0] request_dest,
  output logic [NUM_PROC-1:0]                     processed_request,
  output logic [NUM_PROC-1:0]                     request_out_avail,
  output logic [NUM_PROC-1:0][47:0]               addrs_out
);
  localparam int SW = $clog2(NUM_PROC);
  localparam int DW = SW + 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [SW-1:0]             last_q, last_d;
  logic [DW-1:0]             dest_q, dest_d;
  logic [47:0]               addr_q, addr_d;
  logic [NUM_PROC-1:0]       pr_q, pr_d;
  logic [NUM_PROC-1:0]       oa_q, oa_d;
  logic [NUM_PROC-1:0][47:0] ao_q, ao_d;
  logic                      found;
  logic [SW-1:0]             pick;
  // round-robin search starting just after the last granted source
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NUM_PROC; k++) begin
      if (!found && request_in_avail[(int'(last_q) + k) % NUM_PROC]) begin
        found = 1'b1;
        pick  = SW'((int'(last_q) + k) % NUM_PROC);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    dest_d  = dest_q;
    addr_d  = addr_q;
    pr_d    = '0;
    oa_d    = '0;
    ao_d    = ao_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d    = BUSY;
        last_d     = pick;
        dest_d     = request_dest[pick];
        addr_d     = addrs_in[pick];
        pr_d[pick] = 1'b1;
        cnt_d      = CW'(LATENCY - 1);
      end
    end else if (cnt_q != 0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      state_d = IDLE;
      // out-of-range destinations match no port, so nothing is delivered
      for (int j = 0; j < NUM_PROC; j++) begin
        if (dest_q == DW'(j)) begin
          oa_d[j] = 1'b1;
          ao_d[j] = addr_q;
        end
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SW'(NUM_PROC - 1);
      dest_q  <= '0;
      addr_q  <= '0;
      pr_q    <= '0;
      oa_q    <= '0;
      ao_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      addr_q  <= addr_d;
      pr_q    <= pr_d;
      oa_q    <= oa_d;
      ao_q    <= ao_d;
    end
  end
  assign processed_request = pr_q;
  assign request_out_avail = oa_q;
  assign addrs_out         = ao_q;
endmodule

// File: tb/tb_bus.sv
// tb_bus: vector table plus hand sequences, deliveries checked through a scoreboard
module tb_bus;
  localparam int NP = 4;
  localparam int L  = 4;
  localparam int DW = $clog2(NP) + 1;
  logic                   clk_in = 1'b0;
  logic                   rst_l  = 1'b1;
  logic [NP-1:0]          req;
  logic [NP-1:0][47:0]    ain;
  logic [NP-1:0][DW-1:0]  dst;
  logic [NP-1:0]          pr;
  logic [NP-1:0]          oa;
  logic [NP-1:0][47:0]    ao;
  bus #(.NUM_PROC(NP), .LATENCY(L)) dut (
    .clk_in(clk_in), .rst_l(rst_l), .request_in_avail(req), .addrs_in(ain),
    .request_dest(dst), .processed_request(pr), .request_out_avail(oa), .addrs_out(ao)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {int due; logic [NP-1:0] oa; int dest; logic [47:0] addr;} sb_t;
  typedef struct {int src; int dest; logic [47:0] addr; logic [NP-1:0] epr;} vec_t;
  sb_t         sb[$];
  logic [47:0] shadow[NP];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  task chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task check_outs(input logic [NP-1:0] epr, input logic [NP-1:0] eoa);
    chk("processed_request", 64'(pr), 64'(epr));
    chk("request_out_avail", 64'(oa), 64'(eoa));
    for (int j = 0; j < NP; j++) chk($sformatf("addrs_out[%0d]", j), 64'(ao[j]), 64'(shadow[j]));
  endtask
  task tick(input logic [NP-1:0] epr);
    logic [NP-1:0] eoa;
    sb_t e;
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    eoa = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      eoa = e.oa;
      if (e.oa != 0) shadow[e.dest] = e.addr;
    end
    check_outs(epr, eoa);
    for (int i = 0; i < NP; i++) begin
      if (epr[i]) begin
        e.due  = cyc + L;
        e.dest = int'(dst[i]);
        e.oa   = e.dest < NP ? NP'(1) << e.dest : '0;
        e.addr = ain[i];
        sb.push_back(e);
      end
    end
  endtask
  task drain();
    repeat (L) tick('0);
  endtask
  task do_reset();
    rst_l = 1'b0;
    #1;
    sb.delete();
    for (int j = 0; j < NP; j++) shadow[j] = '0;
    check_outs('0, '0);
    tick('0);
    rst_l = 1'b1;
  endtask
  vec_t v[5];
  initial begin
    req = '0;
    ain = '0;
    dst = '0;
    for (int j = 0; j < NP; j++) shadow[j] = '0;
    v = '{'{1, 2, 48'h1234_5678_9ABC, 4'b0010},
          '{0, 0, 48'hA5A5_0000_0001, 4'b0001},
          '{3, 4, 48'hDEAD_BEEF_0003, 4'b1000},
          '{2, 1, 48'hFFFF_FFFF_FFFF, 4'b0100},
          '{1, 7, 48'h0000_0000_0001, 4'b0010}};
    #2;
    do_reset();
    tick('0);
    for (int n = 0; n < 5; n++) begin
      req[v[n].src] = 1'b1;
      dst[v[n].src] = DW'(v[n].dest);
      ain[v[n].src] = v[n].addr;
      tick(v[n].epr);
      req[v[n].src] = 1'b0;
      drain();
    end
    tick('0);
    do_reset();
    dst[0] = DW'(3); ain[0] = 48'h0000_0000_00A0;
    dst[1] = DW'(0); ain[1] = 48'h0000_0000_00B1;
    dst[3] = DW'(1); ain[3] = 48'h0000_0000_00C3;
    req = 4'b1011;
    tick(4'b0001); req[0] = 1'b0; drain();
    tick(4'b0010); req[1] = 1'b0; drain();
    tick(4'b1000); req[3] = 1'b0; drain();
    tick('0);
    dst[0] = DW'(2); ain[0] = 48'h0101_0101_0101;
    dst[2] = DW'(0); ain[2] = 48'h0202_0202_0202;
    req = 4'b0101;
    tick(4'b0001); drain();
    tick(4'b0100); drain();
    tick(4'b0001); drain();
    tick(4'b0100); req = '0; drain();
    tick('0);
    dst[1] = DW'(3); ain[1] = 48'h1111_2222_3333;
    req[1] = 1'b1;
    tick(4'b0010); req[1] = 1'b0;
    tick('0); tick('0);
    dst[3] = DW'(2); ain[3] = 48'h3333_4444_5555;
    req[3] = 1'b1;
    tick('0); tick('0);
    tick(4'b1000); req[3] = 1'b0; drain();
    tick('0);
    dst[2] = DW'(1); ain[2] = 48'h7777_8888_9999;
    req[2] = 1'b1;
    tick(4'b0100);
    tick('0);
    do_reset();
    tick(4'b0100); req[2] = 1'b0; drain();
    tick('0);
    tick('0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
